game_sequencer: RTL
===================

Name: game_sequencer

Overview:
Central game-flow controller for the Dino VGA game. It sits beside the graphics pipeline and consumes its frame ticks (60 Hz and 20 Hz) and per-pixel collision strobe. It sequences IDLE / START / RUN / DEAD and tells the object generators when to advance, reset and how fast to move. It also maintains a 4-digit BCD score and high score for the score renderer.

Parameters:
SPEED_INIT, 1, obstacle speed after START (pixels per 60 Hz tick)
SPEED_MAX, 7, speed saturation value; must fit 3 bits
SPEED_STEP, 100, score increments between speed-ups (>=1)
DEATH_HOLD, 40, 20 Hz ticks in DEAD before restart is accepted (2 s)

Ports:
clk  in  1  pixel clock
rst  in  1  reset
i_tick_60hz  in  1  one-cycle pulse, frame start
i_tick_20hz  in  1  one-cycle pulse, always coincident with an i_tick_60hz
i_collision  in  1  per-pixel obstacle/player overlap, combinational, any cycle
i_jump_btn  in  1  jump/start button, already synchronised to clk
o_state  out  2  0=IDLE 1=START 2=RUN 3=DEAD
o_run  out  1  objects advance on 60 Hz ticks
o_obj_reset  out  1  one-cycle pulse: object generators reload start positions
o_speed  out  3  current obstacle speed
o_score_bcd  out  16  current score, 4 BCD digits
o_hiscore_bcd  out  16  best score since reset, 4 BCD digits
o_score_tick  out  1  one-cycle pulse when o_score_bcd changes

Behaviour:
- Reset is asynchronous and active-high on rst. Clock is clk, all flops on posedge.
- Reset values: state IDLE, o_run 0, o_obj_reset 0, o_speed SPEED_INIT, score 0, hiscore 0, o_score_tick 0, collision latch 0, hold counter 0, step counter 0, button history 0.
- All outputs are registered or decoded from state only; none depends combinationally on any input.
- Button edge: btn_rise = i_jump_btn & ~btn_prev; btn_prev is registered every cycle.
- IDLE:
  - o_run=0.
  - btn_rise -> START.
- START (exactly one cycle):
  - o_obj_reset=1; o_obj_reset is 0 in every other state.
  - Clears score, step counter, collision latch and hold counter.
  - Loads speed=SPEED_INIT.
  - Unconditional transition to RUN.
- RUN, o_run=1:
  - i_collision=1 in any cycle sets the collision latch.
  - On i_tick_60hz, if latch|i_collision -> DEAD, and the latch is cleared.
  - Otherwise, on i_tick_20hz, the score increments by 1 in BCD with per-digit carry, saturating at 9999. o_score_tick pulses on the cycle after the tick, together with the new score value.
  - At 9999 saturation: no o_score_tick, and the step counter still advances.
  - Collision has priority: on a tick where DEAD is entered, there is no score increment.
  - Step counter: counts increments 0..SPEED_STEP-1. When it wraps, speed increments by 1, saturating at SPEED_MAX.
  - Button is ignored in RUN; jumping is handled elsewhere.
- DEAD, o_run=0:
  - On the entry cycle: if score > hiscore, hiscore <= score. Plain 16-bit unsigned compare is valid for packed BCD. The update is visible on the cycle after the DEAD state appears.
  - Hold counter increments on each i_tick_20hz until it equals DEATH_HOLD, then holds.
  - While hold < DEATH_HOLD, btn_rise is discarded, not queued.
  - After the hold expires, btn_rise -> START.
  - Score is frozen in DEAD.
- rst asserted mid-game returns immediately to reset values, including hiscore.

Optional Feature:
AUTO_RESTART_EN
- Defined: in DEAD, when the hold counter reaches DEATH_HOLD, the block transitions to START on the next cycle without a button press (attract/demo mode). In IDLE, the first i_tick_60hz also -> START.
- Undefined: restart requires btn_rise exactly as in Behaviour.

Test Plan:
- Reset then btn_rise: o_state 0->1->2 on consecutive cycles; o_obj_reset high for exactly 1 cycle; o_speed=1; score 0.
- RUN with 100 i_tick_20hz pulses: o_score_bcd=0x0100 and 100 o_score_tick pulses. o_speed 1->2 on the 100th increment. From 0x0099 the next value is 0x0100.
- i_collision pulsed for 1 cycle mid-frame, then i_tick_60hz+i_tick_20hz coincident: o_state=3, score unchanged, o_run=0. hiscore updated to score one cycle after entering DEAD.
- In DEAD, btn_rise after 10 20 Hz ticks: stays DEAD. After 40 ticks, btn_rise -> START, and score clears while hiscore is retained.
- Preload near saturation (9998 plus 2 ticks): score sticks at 0x9999 with only one o_score_tick. Speed saturates at 7 after repeated steps.
- rst pulsed while in RUN with nonzero score and hiscore: all outputs return to reset values asynchronously. With AUTO_RESTART_EN, DEAD -> START after 40 ticks with no button.

Source files
------------

// File: rtl/game_sequencer.sv
// Dino game flow controller: IDLE/START/RUN/DEAD sequencing, BCD score/hiscore, speed ramp.
// Optional AUTO_RESTART_EN: attract mode, restarts without a button press.
module game_sequencer #(
  parameter int SPEED_INIT = 1,
  parameter int SPEED_MAX  = 7,
  parameter int SPEED_STEP = 100,
  parameter int DEATH_HOLD = 40
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        i_tick_60hz,
  input  logic        i_tick_20hz,
  input  logic        i_collision,
  input  logic        i_jump_btn,
  output logic [1:0]  o_state,
  output logic        o_run,
  output logic        o_obj_reset,
  output logic [2:0]  o_speed,
  output logic [15:0] o_score_bcd,
  output logic [15:0] o_hiscore_bcd,
  output logic        o_score_tick
);

  // state | meaning
  // IDLE  | waiting for first start
  // START | one cycle: reload objects, clear score
  // RUN   | objects advance, score counts
  // DEAD  | frozen, restart after hold time
  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_START = 2'd1,
    S_RUN   = 2'd2,
    S_DEAD  = 2'd3
  } state_t;

  localparam int HW = $clog2(DEATH_HOLD + 1);
  localparam int SW = $clog2(SPEED_STEP + 1);

  state_t        state, next_state;
  logic          btn_prev;
  logic          btn_rise;
  logic          coll_latch;
  logic [HW-1:0] hold_cnt;
  logic [SW-1:0] step_cnt;
  logic [2:0]    speed;
  logic [15:0]   score;
  logic [15:0]   hiscore;
  logic          score_tick;
  logic          hit;
  logic          inc;
  logic          hold_done;
  logic          score_max;

  function automatic logic [15:0] bcd_inc(input logic [15:0] v);
    logic [15:0] r;
    logic        c;
    r = v;
    c = 1'b1;
    for (int d = 0; d < 4; d++) begin
      if (c) begin
        if (r[4*d +: 4] == 4'd9) begin
          r[4*d +: 4] = 4'd0;
        end else begin
          r[4*d +: 4] = r[4*d +: 4] + 4'd1;
          c = 1'b0;
        end
      end
    end
    return r;
  endfunction

  assign btn_rise  = i_jump_btn & ~btn_prev;
  assign hit       = coll_latch | i_collision;
  assign inc       = (state == S_RUN) & i_tick_20hz & ~(i_tick_60hz & hit);
  assign hold_done = (hold_cnt == HW'(DEATH_HOLD));
  assign score_max = (score == 16'h9999);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= S_IDLE;
    else     state <= next_state;
  end

  always_comb begin
    next_state = state;
    case (state)
      S_IDLE: begin
`ifdef AUTO_RESTART_EN
        if (btn_rise || i_tick_60hz) next_state = S_START;
`else
        if (btn_rise) next_state = S_START;
`endif
      end
      S_START: next_state = S_RUN;
      S_RUN: begin
        if (i_tick_60hz && hit) next_state = S_DEAD;
      end
      S_DEAD: begin
`ifdef AUTO_RESTART_EN
        if (hold_done) next_state = S_START;
`else
        if (hold_done && btn_rise) next_state = S_START;
`endif
      end
      default: next_state = S_IDLE;
    endcase
  end

  always_comb begin
    o_run       = (state == S_RUN);
    o_obj_reset = (state == S_START);
    o_state     = state;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      btn_prev   <= 1'b0;
      coll_latch <= 1'b0;
      hold_cnt   <= '0;
      step_cnt   <= '0;
      speed      <= 3'(SPEED_INIT);
      score      <= '0;
      hiscore    <= '0;
      score_tick <= 1'b0;
    end else begin
      btn_prev   <= i_jump_btn;
      score_tick <= 1'b0;
      case (state)
        S_START: begin
          score      <= '0;
          step_cnt   <= '0;
          coll_latch <= 1'b0;
          hold_cnt   <= '0;
          speed      <= 3'(SPEED_INIT);
        end
        S_RUN: begin
          if (i_tick_60hz)      coll_latch <= 1'b0;
          else if (i_collision) coll_latch <= 1'b1;
          if (inc) begin
            if (!score_max) begin
              score      <= bcd_inc(score);
              score_tick <= 1'b1;
            end
            // step counter keeps running at 9999 so the speed ramp is not stalled
            if (step_cnt == SW'(SPEED_STEP - 1)) begin
              step_cnt <= '0;
              if (speed < 3'(SPEED_MAX)) speed <= speed + 3'd1;
            end else begin
              step_cnt <= step_cnt + SW'(1);
            end
          end
        end
        S_DEAD: begin
          // packed BCD orders the same as unsigned binary
          if (score > hiscore) hiscore <= score;
          if (i_tick_20hz && !hold_done) hold_cnt <= hold_cnt + HW'(1);
        end
        default: ;
      endcase
    end
  end

  assign o_speed       = speed;
  assign o_score_bcd   = score;
  assign o_hiscore_bcd = hiscore;
  assign o_score_tick  = score_tick;

endmodule
